// File: rtl/memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : memory_arbiter
// Brief    : Round-robin arbiter sharing one Memory block between two masters.
//            Define ARB_TIMEOUT_EN to add the BUSY-cycle abort watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module memory_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_read_request,
  input  logic                  m0_write_request,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_write_data,
  output logic [DATA_WIDTH-1:0] m0_read_data,
  output logic                  m0_response,
  input  logic                  m1_read_request,
  input  logic                  m1_write_request,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_write_data,
  output logic [DATA_WIDTH-1:0] m1_read_data,
  output logic                  m1_response,
  output logic                  memory_read_request,
  output logic                  memory_write_request,
  output logic [ADDR_WIDTH-1:0] memory_addr,
  output logic [DATA_WIDTH-1:0] memory_write_data,
  input  logic [DATA_WIDTH-1:0] memory_read_data,
  input  logic                  memory_response,
  output logic                  timeout_error
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam logic [DATA_WIDTH-1:0] c_abort_data = DATA_WIDTH'(32'hDEADBEEF);

  state_t                r_state;
  state_t                w_state_next;
  logic                  r_grant;
  logic                  r_last_grant;
  logic                  w_m0_req;
  logic                  w_m1_req;
  logic                  w_start;
  logic                  w_grant_next;
  logic                  w_done;
  logic                  w_abort;
  logic                  w_timeout_hit;
  logic                  w_sel_write;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_wdata;
  logic [DATA_WIDTH-1:0] w_ret_data;

  generate
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("memory_arbiter: TIMEOUT_CYCLES must be in 1..65535");
    end
  endgenerate

  assign w_m0_req    = m0_read_request | m0_write_request;
  assign w_m1_req    = m1_read_request | m1_write_request;
  // A write request always wins over a simultaneous read on the same port.
  assign w_sel_write = w_grant_next ? m1_write_request : m0_write_request;
  assign w_sel_addr  = w_grant_next ? m1_addr : m0_addr;
  assign w_sel_wdata = w_grant_next ? m1_write_data : m0_write_data;
  assign w_ret_data  = w_abort ? c_abort_data : memory_read_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_grant_next = r_grant;
    w_done       = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_m0_req && w_m1_req) begin
          w_start      = 1'b1;
          w_grant_next = ~r_last_grant;
        end else if (w_m0_req) begin
          w_start      = 1'b1;
          w_grant_next = 1'b0;
        end else if (w_m1_req) begin
          w_start      = 1'b1;
          w_grant_next = 1'b1;
        end
        if (w_start) w_state_next = BUSY;
      end
      BUSY: begin
        if (memory_response) begin
          w_done       = 1'b1;
          w_state_next = RELEASE;
        end else if (w_timeout_hit) begin
          w_abort      = 1'b1;
          w_state_next = RELEASE;
        end
      end
      RELEASE: w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grant              <= 1'b0;
      r_last_grant         <= 1'b1;
      memory_read_request  <= 1'b0;
      memory_write_request <= 1'b0;
      memory_addr          <= '0;
      memory_write_data    <= '0;
      m0_read_data         <= '0;
      m0_response          <= 1'b0;
      m1_read_data         <= '0;
      m1_response          <= 1'b0;
    end else begin
      m0_response <= 1'b0;
      m1_response <= 1'b0;
      if (w_start) begin
        r_grant              <= w_grant_next;
        r_last_grant         <= w_grant_next;
        memory_read_request  <= ~w_sel_write;
        memory_write_request <= w_sel_write;
        memory_addr          <= w_sel_addr;
        memory_write_data    <= w_sel_wdata;
      end
      if (w_done || w_abort) begin
        memory_read_request  <= 1'b0;
        memory_write_request <= 1'b0;
        if (r_grant) begin
          m1_response  <= 1'b1;
          m1_read_data <= w_ret_data;
        end else begin
          m0_response  <= 1'b1;
          m0_read_data <= w_ret_data;
        end
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [15:0] c_timeout_last = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] r_busy_count;
  logic        r_timeout_error;

  // Count equals the number of BUSY cycles already elapsed before this one.
  assign w_timeout_hit = (r_busy_count == c_timeout_last);
  assign timeout_error = r_timeout_error;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy_count    <= 16'd0;
      r_timeout_error <= 1'b0;
    end else begin
      if (w_start)              r_busy_count <= 16'd0;
      else if (r_state == BUSY) r_busy_count <= r_busy_count + 16'd1;
      if (w_abort) r_timeout_error <= 1'b1;
    end
  end
`else
  assign w_timeout_hit = 1'b0;
  assign timeout_error = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_memory_arbiter
// Brief    : Self-checking bench for memory_arbiter: directed vectors, corner
//            sequences and randomized two-master traffic against a memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_memory_arbiter;
  localparam int DW   = 32;
  localparam int AW   = 32;
  localparam int TOUT = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          m0_read_request = 1'b0, m0_write_request = 1'b0;
  logic [AW-1:0] m0_addr = '0;
  logic [DW-1:0] m0_write_data = '0;
  logic [DW-1:0] m0_read_data;
  logic          m0_response;
  logic          m1_read_request = 1'b0, m1_write_request = 1'b0;
  logic [AW-1:0] m1_addr = '0;
  logic [DW-1:0] m1_write_data = '0;
  logic [DW-1:0] m1_read_data;
  logic          m1_response;
  logic          memory_read_request, memory_write_request;
  logic [AW-1:0] memory_addr;
  logic [DW-1:0] memory_write_data;
  logic [DW-1:0] memory_read_data = '0;
  logic          memory_response = 1'b0;
  logic          timeout_error;

  always #5 clk = ~clk;

  memory_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TOUT)) dut (
    .clk(clk), .rst(rst),
    .m0_read_request(m0_read_request), .m0_write_request(m0_write_request),
    .m0_addr(m0_addr), .m0_write_data(m0_write_data),
    .m0_read_data(m0_read_data), .m0_response(m0_response),
    .m1_read_request(m1_read_request), .m1_write_request(m1_write_request),
    .m1_addr(m1_addr), .m1_write_data(m1_write_data),
    .m1_read_data(m1_read_data), .m1_response(m1_response),
    .memory_read_request(memory_read_request), .memory_write_request(memory_write_request),
    .memory_addr(memory_addr), .memory_write_data(memory_write_data),
    .memory_read_data(memory_read_data), .memory_response(memory_response),
    .timeout_error(timeout_error)
  );

  int checks = 0;
  int errors = 0;

  // Unwritten memory words read back as a fixed function of their address.
  function automatic logic [31:0] init_val(input logic [7:0] a);
    return 32'h12345668 + {24'h0, a};
  endfunction

  // Memory model: answers after stall_cfg extra cycles (negative = random 0..3).
  logic [31:0] mem [256];
  bit          written [256];
  int          stall_cfg = 0;
  int          cnt = 0;
  int          cur_stall = 0;

  always @(negedge clk) begin
    memory_response = 1'b0;
    if (rst || !(memory_read_request || memory_write_request)) begin
      cnt = 0;
    end else begin
      if (cnt == 0) cur_stall = (stall_cfg < 0) ? int'($urandom_range(0, 3)) : stall_cfg;
      if (cnt == cur_stall) begin
        memory_response = 1'b1;
        if (memory_write_request) begin
          mem[memory_addr[7:0]]     = memory_write_data;
          written[memory_addr[7:0]] = 1'b1;
          memory_read_data          = $urandom;
        end else begin
          memory_read_data = written[memory_addr[7:0]] ? mem[memory_addr[7:0]]
                                                       : init_val(memory_addr[7:0]);
        end
        cnt = 0;
      end else begin
        cnt++;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input int p, input bit rd, input bit wr,
                       input logic [31:0] a, input logic [31:0] d);
    if (p == 0) begin
      m0_read_request = rd; m0_write_request = wr; m0_addr = a; m0_write_data = d;
    end else begin
      m1_read_request = rd; m1_write_request = wr; m1_addr = a; m1_write_data = d;
    end
  endtask

  function automatic logic resp(input int p);
    return (p != 0) ? m1_response : m0_response;
  endfunction

  function automatic logic [31:0] rdata(input int p);
    return (p != 0) ? m1_read_data : m0_read_data;
  endfunction

  typedef struct {
    int          port;
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          stall;
    bit          exp_mrd;
    bit          exp_mwr;
    bit          chk_rdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [5];

  // Reference model for randomized traffic.
  logic [31:0] ref_mem [256];
  int          last_port = -1;
  int          done_cnt [2];

  task automatic apply_vec(input vec_t v);
    stall_cfg = v.stall;
    drive(v.port, v.rd, v.wr, v.addr, v.wdata);
    @(negedge clk);
    chk("vec_mem_rd", 32'(memory_read_request), 32'(v.exp_mrd));
    chk("vec_mem_wr", 32'(memory_write_request), 32'(v.exp_mwr));
    chk("vec_mem_addr", memory_addr, v.addr);
    if (v.exp_mwr) chk("vec_mem_wdata", memory_write_data, v.wdata);
    for (int s = 0; s < v.stall; s++) begin
      @(negedge clk);
      chk("vec_req_held", {30'h0, memory_read_request, memory_write_request},
          {30'h0, v.exp_mrd, v.exp_mwr});
      chk("vec_no_early_resp", {31'h0, resp(v.port)}, 32'h0);
    end
    @(negedge clk);
    chk("vec_resp", {31'h0, resp(v.port)}, 32'h1);
    chk("vec_other_resp", {31'h0, resp(1 - v.port)}, 32'h0);
    chk("vec_req_dropped", {30'h0, memory_read_request, memory_write_request}, 32'h0);
    if (v.chk_rdata) chk("vec_rdata", rdata(v.port), v.exp_rdata);
    drive(v.port, 1'b0, 1'b0, v.addr, v.wdata);
    @(negedge clk);
    chk("vec_pulse_end", {31'h0, resp(v.port)}, 32'h0);
    if (v.chk_rdata) chk("vec_rdata_hold", rdata(v.port), v.exp_rdata);
  endtask

  task automatic master(input int p, input int n, input int gap_max, input bit strict);
    for (int t = 0; t < n; t++) begin
      int          gap, w, other0;
      bit          rd, wr;
      logic [7:0]  idx;
      logic [31:0] a, d;
      gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      repeat (gap) @(negedge clk);
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      if (!rd && !wr) rd = 1'b1;
      idx = 8'h80 + 8'($urandom_range(0, 31) * 4);
      a = {24'h0, idx};
      d = $urandom;
      other0 = done_cnt[1 - p];
      drive(p, rd, wr, a, d);
      w = 0;
      do begin
        @(negedge clk);
        w++;
      end while (!resp(p) && w < 300);
      chk("rand_resp_seen", {31'h0, resp(p)}, 32'h1);
      if (wr) ref_mem[idx] = d;
      else    chk("rand_read_data", rdata(p), ref_mem[idx]);
      chk("rand_wait_bound", 32'(done_cnt[1 - p] - other0 <= 1), 32'h1);
      if (strict && last_port >= 0) chk("rand_alternate", 32'(p), 32'(1 - last_port));
      last_port = p;
      done_cnt[p]++;
      drive(p, 1'b0, 1'b0, a, d);
      @(negedge clk);
      chk("rand_pulse_end", {31'h0, resp(p)}, 32'h0);
    end
  endtask

  initial begin
    int w, exp_p, busy;

    vecs[0] = '{0, 1'b1, 1'b0, 32'h10, 32'h0,        0, 1'b1, 1'b0, 1'b1, 32'h12345678};
    vecs[1] = '{1, 1'b0, 1'b1, 32'h20, 32'hCAFEBABE, 0, 1'b0, 1'b1, 1'b0, 32'h0};
    vecs[2] = '{0, 1'b1, 1'b1, 32'h24, 32'h11112222, 5, 1'b0, 1'b1, 1'b0, 32'h0};
    vecs[3] = '{1, 1'b1, 1'b0, 32'h20, 32'h0,        2, 1'b1, 1'b0, 1'b1, 32'hCAFEBABE};
    vecs[4] = '{0, 1'b1, 1'b0, 32'h30, 32'h0,        1, 1'b1, 1'b0, 1'b1, 32'h12345698};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_mem_rd", 32'(memory_read_request), 32'h0);
    chk("rst_mem_wr", 32'(memory_write_request), 32'h0);
    chk("rst_mem_addr", memory_addr, 32'h0);
    chk("rst_mem_wdata", memory_write_data, 32'h0);
    chk("rst_resp", {30'h0, m0_response, m1_response}, 32'h0);
    chk("rst_m0_rdata", m0_read_data, 32'h0);
    chk("rst_m1_rdata", m1_read_data, 32'h0);
    chk("rst_timeout_error", 32'(timeout_error), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Contention straight after reset: both held, grants alternate from port 0
    stall_cfg = 0;
    drive(0, 1'b1, 1'b0, 32'h100, 32'h0);
    drive(1, 1'b1, 1'b0, 32'h104, 32'h0);
    exp_p = 0;
    for (int k = 0; k < 4; k++) begin
      w = 0;
      do begin
        @(negedge clk);
        w++;
      end while (!m0_response && !m1_response && w < 50);
      chk("contention_resp", {31'h0, m0_response | m1_response}, 32'h1);
      chk("contention_order", {31'h0, m1_response}, 32'(exp_p));
      chk("contention_rdata", rdata(exp_p), init_val(exp_p ? 8'h04 : 8'h00));
      if (k == 0) chk("unserved_rdata_zero", m1_read_data, 32'h0);
      exp_p = 1 - exp_p;
    end
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);

    // Reset in the middle of a stalled port-0 access
    stall_cfg = 1000;
    drive(0, 1'b1, 1'b0, 32'h40, 32'h0);
    repeat (3) @(negedge clk);
    chk("midbusy_req_before", 32'(memory_read_request), 32'h1);
    #3 rst = 1'b1;
    #1;
    chk("midbusy_req_async", {30'h0, memory_read_request, memory_write_request}, 32'h0);
    chk("midbusy_addr_async", memory_addr, 32'h0);
    chk("midbusy_rdata_async", m0_read_data, 32'h0);
    repeat (2) begin
      @(negedge clk);
      chk("midbusy_no_resp", {30'h0, m0_response, m1_response}, 32'h0);
    end
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    rst = 1'b0;
    stall_cfg = 0;
    @(negedge clk);
    chk("midbusy_no_resp_after", {30'h0, m0_response, m1_response}, 32'h0);
    drive(0, 1'b1, 1'b0, 32'h100, 32'h0);
    drive(1, 1'b1, 1'b0, 32'h104, 32'h0);
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!m0_response && !m1_response && w < 50);
    chk("post_reset_grant", {30'h0, m0_response, m1_response}, 32'h2);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);

    // Directed single-transaction vectors
    for (int i = 0; i < 5; i++) apply_vec(vecs[i]);

`ifdef ARB_TIMEOUT_EN
    stall_cfg = 100000;
    drive(0, 1'b1, 1'b0, 32'h50, 32'h0);
    busy = 0;
    @(negedge clk);
    while (memory_read_request && busy < 100) begin
      busy++;
      @(negedge clk);
    end
    chk("timeout_busy_cycles", 32'(busy), 32'(TOUT));
    chk("timeout_resp", 32'(m0_response), 32'h1);
    chk("timeout_rdata", m0_read_data, 32'hDEADBEEF);
    chk("timeout_flag", 32'(timeout_error), 32'h1);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    chk("timeout_flag_sticky", 32'(timeout_error), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    stall_cfg = 0;
    @(negedge clk);
`else
    busy = 0;
`endif

    // Randomized two-master traffic
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
    stall_cfg = -1;
    last_port = -1;
    fork
      master(0, 12, 0, 1'b1);
      master(1, 12, 0, 1'b1);
    join
    last_port = -1;
    fork
      master(0, 15, 4, 1'b0);
      master(1, 15, 4, 1'b0);
    join

    chk("final_timeout_error", 32'(timeout_error), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
